// File: rtl/flow_queue.sv
// rtl/flow_queue.sv - parametrised val/rdy FIFO with normal, bypass and pipe flow modes
module flow_queue #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int MODE      = 0,
    parameter int AF_THRESH = (DEPTH > 1) ? DEPTH - 1 : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           recv_msg,
    input  logic                       recv_val,
    output logic                       recv_rdy,
    output logic [WIDTH-1:0]           send_msg,
    output logic                       send_val,
    input  logic                       send_rdy,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

    // Reject configurations that have no defined behaviour
    generate
        if (MODE < 0 || MODE > 2) begin : g_bad_mode
            $error("flow_queue: MODE must be 0, 1 or 2");
        end
        if (DEPTH < 1 || WIDTH < 1) begin : g_bad_size
            $error("flow_queue: DEPTH and WIDTH must be >= 1");
        end
        if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
            $error("flow_queue: AF_THRESH must lie in 1..DEPTH");
        end
    endgenerate

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [WIDTH-1:0] head_data;

    logic full;
    logic empty;
    logic enq;
    logic deq;
    logic passthrough;
    logic write;
    logic read;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    // Ready/valid: clear blocks both sides so nothing completes during a flush
    always_comb begin
        recv_rdy = 1'b0;
        send_val = 1'b0;
        if (!clear) begin
            recv_rdy = (MODE == 2) ? (!full || send_rdy) : !full;
            send_val = (MODE == 1) ? (!empty || recv_val) : !empty;
        end
    end

    // Head entry lookup; a compare-select keeps non-power-of-two depths in range
    always_comb begin
        head_data = mem[0];
        for (int i = 0; i < DEPTH; i++) begin
            if (head == PW'(i)) begin
                head_data = mem[i];
            end
        end
    end

    assign send_msg = (MODE == 1 && empty) ? recv_msg : head_data;

    assign enq         = recv_val && recv_rdy;
    assign deq         = send_val && send_rdy;
    // Bypass when empty: the message goes straight through and is never stored
    assign passthrough = (MODE == 1) && empty && enq && deq;
    assign write       = enq && !passthrough;
    assign read        = deq && !passthrough;

    assign almost_full = (count >= AF_C);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_P) ? '0 : p + 1'b1;
    endfunction

    // Payload storage, written at the tail slot on a stored enqueue
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (write && tail == PW'(i)) begin
                mem[i] <= recv_msg;
            end
        end
    end

    // Pointers and occupancy; clear flushes, reset dominates everything
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (write) begin
                tail <= ptr_inc(tail);
            end
            if (read) begin
                head <= ptr_inc(head);
            end
            count <= count + CW'(write) - CW'(read);
        end
    end

endmodule

// File: tb/tb_flow_queue.sv
// tb/tb_flow_queue.sv - randomized and directed checks of flow_queue against a list model
module tb_flow_queue;

    localparam int N = 4;
    localparam int MODES  [N] = '{0, 1, 2, 2};
    localparam int DEPTHS [N] = '{3, 4, 2, 1};
    localparam int AFS    [N] = '{2, 3, 2, 1};

    logic       clk;
    logic       reset;
    logic       clear_a    [N];
    logic [7:0] recv_msg_a [N];
    logic       recv_val_a [N];
    logic       recv_rdy_a [N];
    logic [7:0] send_msg_a [N];
    logic       send_val_a [N];
    logic       send_rdy_a [N];
    logic [7:0] cnt_a      [N];
    logic       af_a       [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int CWG = $clog2(DEPTHS[g] + 1);
        logic [CWG-1:0] cnt_w;
        flow_queue #(
            .WIDTH    (8),
            .DEPTH    (DEPTHS[g]),
            .MODE     (MODES[g]),
            .AF_THRESH(AFS[g])
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .clear      (clear_a[g]),
            .recv_msg   (recv_msg_a[g]),
            .recv_val   (recv_val_a[g]),
            .recv_rdy   (recv_rdy_a[g]),
            .send_msg   (send_msg_a[g]),
            .send_val   (send_val_a[g]),
            .send_rdy   (send_rdy_a[g]),
            .count      (cnt_w),
            .almost_full(af_a[g])
        );
        assign cnt_a[g] = 8'(cnt_w);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: per-instance ordered list, element 0 is the oldest
    logic [7:0] mlist [N][16];
    int         mn    [N];
    logic       obs_enq [N];
    logic       obs_deq [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) mn[i] = 0;
    endtask

    task automatic idle_all();
        for (int i = 0; i < N; i++) begin
            clear_a[i]    = 1'b0;
            recv_val_a[i] = 1'b0;
            send_rdy_a[i] = 1'b0;
            recv_msg_a[i] = 8'h00;
        end
    endtask

    // One clock: check every instance mid-cycle, then advance the model at the edge
    task automatic cycle();
        logic e_rdy [N];
        logic e_val [N];
        logic do_enq [N];
        logic do_deq [N];
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            int d = DEPTHS[i];
            int n = mn[i];
            e_rdy[i] = !clear_a[i] && ((MODES[i] == 2) ? (n < d || send_rdy_a[i]) : (n < d));
            e_val[i] = !clear_a[i] && ((MODES[i] == 1) ? (n > 0 || recv_val_a[i]) : (n > 0));
            check($sformatf("u%0d_recv_rdy", i), 32'(recv_rdy_a[i]), 32'(e_rdy[i]));
            check($sformatf("u%0d_send_val", i), 32'(send_val_a[i]), 32'(e_val[i]));
            check($sformatf("u%0d_count", i), 32'(cnt_a[i]), 32'(n));
            check($sformatf("u%0d_almost_full", i), 32'(af_a[i]), 32'(n >= AFS[i]));
            if (e_val[i]) begin
                check($sformatf("u%0d_send_msg", i), 32'(send_msg_a[i]),
                      32'((n > 0) ? mlist[i][0] : recv_msg_a[i]));
            end
            do_enq[i]  = recv_val_a[i] && e_rdy[i];
            do_deq[i]  = e_val[i] && send_rdy_a[i];
            obs_enq[i] = recv_val_a[i] && recv_rdy_a[i];
            obs_deq[i] = send_val_a[i] && send_rdy_a[i];
        end
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (clear_a[i]) begin
                mn[i] = 0;
            end else if (!(MODES[i] == 1 && mn[i] == 0 && do_enq[i] && do_deq[i])) begin
                if (do_deq[i]) begin
                    for (int k = 1; k < mn[i]; k++) mlist[i][k-1] = mlist[i][k];
                    mn[i]--;
                end
                if (do_enq[i]) begin
                    mlist[i][mn[i]] = recv_msg_a[i];
                    mn[i]++;
                end
            end
        end
        #1;
    endtask

    logic [7:0] got_q [$];

    initial begin
        int idx;
        int budget;
        idle_all();
        model_reset();
        reset = 1'b0;
        #22;
        check("reset_count", 32'(cnt_a[0]), 32'd0);
        check("reset_send_val", 32'(send_val_a[0]), 32'd0);
        check("reset_recv_rdy", 32'(recv_rdy_a[0]), 32'd1);
        check("reset_af", 32'(af_a[0]), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Normal mode fill to full then drain in order
        for (int k = 0; k < 3; k++) begin
            recv_val_a[0] = 1'b1;
            recv_msg_a[0] = 8'hA1 + 8'(k);
            cycle();
        end
        recv_val_a[0] = 1'b0;
        #1;
        check("fill_count", 32'(cnt_a[0]), 32'd3);
        check("fill_recv_rdy", 32'(recv_rdy_a[0]), 32'd0);
        check("fill_af", 32'(af_a[0]), 32'd1);
        send_rdy_a[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("drain_msg", 32'(send_msg_a[0]), 32'(8'hA1 + 8'(k)));
            cycle();
        end
        check("drain_count", 32'(cnt_a[0]), 32'd0);
        idle_all();

        // Wrap: stream ten items with random backpressure
        idx = 0;
        budget = 0;
        got_q.delete();
        while (got_q.size() < 10 && budget < 300) begin
            recv_val_a[0] = (idx < 10);
            recv_msg_a[0] = 8'h10 + 8'(idx);
            send_rdy_a[0] = 1'($urandom_range(0, 1));
            #1;
            if (send_val_a[0] && send_rdy_a[0]) got_q.push_back(send_msg_a[0]);
            cycle();
            if (obs_enq[0]) idx++;
            budget++;
        end
        check("wrap_items_out", 32'(got_q.size()), 32'd10);
        for (int k = 0; k < got_q.size(); k++) check("wrap_order", 32'(got_q[k]), 32'(8'h10 + 8'(k)));
        idle_all();

        // Bypass: empty queue passes straight through
        recv_val_a[1] = 1'b1;
        recv_msg_a[1] = 8'h5C;
        send_rdy_a[1] = 1'b1;
        #1;
        check("byp_send_val", 32'(send_val_a[1]), 32'd1);
        check("byp_send_msg", 32'(send_msg_a[1]), 32'h5C);
        cycle();
        check("byp_count", 32'(cnt_a[1]), 32'd0);
        send_rdy_a[1] = 1'b0;
        cycle();
        check("byp_stored_count", 32'(cnt_a[1]), 32'd1);
        recv_val_a[1] = 1'b0;
        send_rdy_a[1] = 1'b1;
        cycle();
        idle_all();

        // Pipe depth 2: full with send_rdy accepts and releases together
        for (int k = 0; k < 2; k++) begin
            recv_val_a[2] = 1'b1;
            recv_msg_a[2] = 8'h01 + 8'(k);
            cycle();
        end
        recv_msg_a[2] = 8'h03;
        send_rdy_a[2] = 1'b1;
        #1;
        check("pipe_recv_rdy", 32'(recv_rdy_a[2]), 32'd1);
        check("pipe_head", 32'(send_msg_a[2]), 32'h01);
        cycle();
        check("pipe_count", 32'(cnt_a[2]), 32'd2);
        recv_val_a[2] = 1'b0;
        #1;
        check("pipe_next0", 32'(send_msg_a[2]), 32'h02);
        cycle();
        check("pipe_next1", 32'(send_msg_a[2]), 32'h03);
        cycle();
        idle_all();

        // Clear with a pending enqueue
        for (int k = 0; k < 2; k++) begin
            recv_val_a[0] = 1'b1;
            recv_msg_a[0] = 8'h40 + 8'(k);
            cycle();
        end
        clear_a[0]    = 1'b1;
        recv_msg_a[0] = 8'hEE;
        #1;
        check("clr_recv_rdy", 32'(recv_rdy_a[0]), 32'd0);
        check("clr_send_val", 32'(send_val_a[0]), 32'd0);
        cycle();
        idle_all();
        #1;
        check("clr_count", 32'(cnt_a[0]), 32'd0);
        check("clr_send_val_after", 32'(send_val_a[0]), 32'd0);
        cycle();

        // Asynchronous reset mid-stream
        for (int k = 0; k < 2; k++) begin
            recv_val_a[0] = 1'b1;
            recv_msg_a[0] = 8'h60 + 8'(k);
            cycle();
        end
        idle_all();
        #1;
        reset = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("rst_u%0d_count", i), 32'(cnt_a[i]), 32'd0);
            check($sformatf("rst_u%0d_send_val", i), 32'(send_val_a[i]), 32'd0);
        end
        model_reset();
        #1;
        reset = 1'b1;
        recv_val_a[0] = 1'b1;
        recv_msg_a[0] = 8'h77;
        cycle();
        recv_val_a[0] = 1'b0;
        send_rdy_a[0] = 1'b1;
        #1;
        check("rst_first_out", 32'(send_msg_a[0]), 32'h77);
        cycle();
        idle_all();

        // Randomized traffic on all instances
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                recv_val_a[i] = 1'($urandom_range(0, 1));
                recv_msg_a[i] = 8'($urandom);
                send_rdy_a[i] = ($urandom_range(0, 3) != 0);
                clear_a[i]    = ($urandom_range(0, 31) == 0);
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
